// File: rtl/pe_act_serializer.sv
// Activation-vector to bit-plane serializer for the PE input bus.
// One active slot streams LSB-first planes; one pending slot lets the loader run ahead.
module pe_act_serializer #(
    parameter int PE_SIZE     = 1024,
    parameter int ACT_BITS    = 4,
    parameter int SIGNED_ACTS = 0,
    parameter int CNT_W       = 16,
    localparam int PLANE_W    = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1,
    localparam int VEC_W      = PE_SIZE * ACT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 act_valid_i,
    output logic                 act_ready_o,
    input  logic [VEC_W-1:0]     act_i,
    output logic                 pe_valid_o,
    input  logic                 pe_ready_i,
    output logic [PE_SIZE-1:0]   pe_data_o,
    output logic [PLANE_W-1:0]   pe_plane_o,
    output logic                 pe_last_o,
    output logic                 pe_sign_o,
    output logic [CNT_W-1:0]     vec_cnt_o,
    output logic                 busy_o
);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(ACT_BITS - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   active_q, active_d;
    logic [VEC_W-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic active_valid;
    logic accept;
    logic beat;
    logic retire;

    assign active_valid = (state_q == S_SEND);
    // Ready depends only on reset and the pending flag, never on pe_ready_i.
    assign act_ready_o  = !rst && !pend_valid_q;
    assign accept       = act_valid_i && act_ready_o;
    assign beat         = active_valid && pe_ready_i;
    assign retire       = beat && (plane_q == LAST_PLANE);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        plane_d      = plane_q;
        cnt_d        = cnt_q;

        if (beat) begin
            if (retire) begin
                plane_d = '0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (pend_valid_q) begin
                    active_d     = pend_q;
                    pend_valid_d = 1'b0;
                end else if (accept) begin
                    active_d = act_i;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                plane_d = plane_q + PLANE_W'(1);
            end
        end

        // A same-edge accept during retire was already routed into the active slot above.
        if (accept) begin
            if (state_q == S_IDLE) begin
                active_d = act_i;
                state_d  = S_SEND;
            end else if (!retire) begin
                pend_d       = act_i;
                pend_valid_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            plane_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            plane_q      <= plane_d;
            cnt_q        <= cnt_d;
            // NOTE: the wide vector registers are not reset; their valid flags make stale contents invisible.
            active_q     <= active_d;
            pend_q       <= pend_d;
        end
    end

    always_comb begin
        pe_data_o = '0;
        if (active_valid) begin
            for (int i = 0; i < PE_SIZE; i++) begin
                pe_data_o[i] = active_q[i*ACT_BITS + int'(plane_q)];
            end
        end
    end

    assign pe_valid_o = active_valid;
    assign pe_plane_o = plane_q;
    assign pe_last_o  = active_valid && (plane_q == LAST_PLANE);
    assign pe_sign_o  = pe_last_o && (SIGNED_ACTS != 0);
    assign vec_cnt_o  = cnt_q;
    assign busy_o     = active_valid || pend_valid_q;

endmodule

// File: tb/tb_pe_act_serializer.sv
// Directed and randomized bench for pe_act_serializer against a queue-based reference model.
module tb_pe_act_serializer;

    localparam int PE_SIZE  = 8;
    localparam int ACT_BITS = 4;
    localparam int SIGNED   = 1;
    localparam int CNT_W    = 4;

    logic        clk;
    logic        rst;
    logic        act_valid_i;
    logic        act_ready_o;
    logic [31:0] act_i;
    logic        pe_valid_o;
    logic        pe_ready_i;
    logic [7:0]  pe_data_o;
    logic [1:0]  pe_plane_o;
    logic        pe_last_o;
    logic        pe_sign_o;
    logic [3:0]  vec_cnt_o;
    logic        busy_o;

    pe_act_serializer #(
        .PE_SIZE    (PE_SIZE),
        .ACT_BITS   (ACT_BITS),
        .SIGNED_ACTS(SIGNED),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .act_valid_i(act_valid_i),
        .act_ready_o(act_ready_o),
        .act_i      (act_i),
        .pe_valid_o (pe_valid_o),
        .pe_ready_i (pe_ready_i),
        .pe_data_o  (pe_data_o),
        .pe_plane_o (pe_plane_o),
        .pe_last_o  (pe_last_o),
        .pe_sign_o  (pe_sign_o),
        .vec_cnt_o  (vec_cnt_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO of accepted vectors (at most active + pending), current plane, count.
    logic [31:0] mq[$];
    int          m_plane = 0;
    int          m_cnt   = 0;
    logic        m_acc;
    logic        m_beat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] plane_of(input logic [31:0] vec, input int k);
        logic [7:0] r;
        for (int i = 0; i < PE_SIZE; i++) r[i] = vec[i*ACT_BITS + k];
        return r;
    endfunction

    // Drive inputs for one cycle, compare every output to the model, then advance both.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic pr);
        logic       e_valid;
        logic       e_last;
        logic [7:0] e_data;
        rst = r; act_valid_i = v; act_i = a; pe_ready_i = pr;
        #1;
        e_valid = (mq.size() > 0);
        e_last  = e_valid && (m_plane == ACT_BITS - 1);
        e_data  = e_valid ? plane_of(mq[0], m_plane) : 8'h00;
        check("act_ready", 32'(act_ready_o), 32'(!r && (mq.size() < 2)));
        check("pe_valid",  32'(pe_valid_o),  32'(e_valid));
        check("pe_data",   32'(pe_data_o),   32'(e_data));
        check("pe_plane",  32'(pe_plane_o),  32'(m_plane));
        check("pe_last",   32'(pe_last_o),   32'(e_last));
        check("pe_sign",   32'(pe_sign_o),   32'(e_last && (SIGNED != 0)));
        check("busy",      32'(busy_o),      32'(e_valid));
        check("vec_cnt",   32'(vec_cnt_o),   32'(m_cnt));
        m_acc  = !r && v && (mq.size() < 2);
        m_beat = e_valid && pr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_plane = 0;
            m_cnt   = 0;
        end else begin
            if (m_beat) begin
                if (m_plane == ACT_BITS - 1) begin
                    void'(mq.pop_front());
                    m_plane = 0;
                    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                end else begin
                    m_plane++;
                end
            end
            if (m_acc) mq.push_back(a);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  single_exp [4];
        logic [31:0] bb [3];
        logic [31:0] va, vb;
        logic [3:0]  c0;
        logic [8:0]  bp_ready;
        int          v, nbeats, first_c, last_c;

        single_exp[0] = 8'hD5; single_exp[1] = 8'hE6;
        single_exp[2] = 8'hF8; single_exp[3] = 8'h80;

        rst = 1'b1; act_valid_i = 1'b0; act_i = '0; pe_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with upstream valid: nothing accepted, all outputs idle.
        repeat (3) step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_release_ready", 32'(act_ready_o), 32'd1);
        check("rst_release_busy",  32'(busy_o),      32'd0);

        // Single vector {1,2,3,4,5,6,7,15}.
        step(1'b0, 1'b1, 32'hF765_4321, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("single_data", 32'(pe_data_o), 32'(single_exp[k]));
            check("single_last", 32'(pe_last_o), 32'(k == 3));
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check("single_cnt",   32'(vec_cnt_o),  32'd1);
        check("single_valid", 32'(pe_valid_o), 32'd0);

        // Back-to-back: three vectors offered continuously.
        for (int i = 0; i < 3; i++) bb[i] = $urandom;
        v = 0; nbeats = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 30; c++) begin
            if (pe_valid_o) begin
                nbeats++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            step(1'b0, v < 3, bb[(v < 3) ? v : 0], 1'b1);
            if (m_acc) v++;
        end
        check("b2b_beats", 32'(nbeats),              32'd12);
        check("b2b_span",  32'(last_c - first_c + 1), 32'd12);
        check("b2b_cnt",   32'(vec_cnt_o),           32'd4);

        // Backpressure: five stalled cycles at plane 2.
        va = $urandom;
        c0 = vec_cnt_o;
        bp_ready = 9'b1_1000_0011;
        step(1'b0, 1'b1, va, 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (k >= 2 && k <= 7) begin
                check("bp_plane", 32'(pe_plane_o), 32'd2);
                check("bp_data",  32'(pe_data_o),  32'(plane_of(va, 2)));
            end
            if (k == 8) check("bp_cnt_not_yet", 32'(vec_cnt_o), 32'(c0));
            step(1'b0, 1'b0, 32'h0, bp_ready[k]);
        end
        check("bp_cnt_done", 32'(vec_cnt_o),  32'(c0 + 4'd1));
        check("bp_idle",     32'(pe_valid_o), 32'd0);

        // Same-edge retire of A and accept of B with pending empty.
        va = $urandom; vb = $urandom;
        step(1'b0, 1'b1, va, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("same_a_last", 32'(pe_last_o), 32'd1);
        step(1'b0, 1'b1, vb, 1'b1);
        check("same_b_valid", 32'(pe_valid_o),  32'd1);
        check("same_b_plane", 32'(pe_plane_o),  32'd0);
        check("same_b_data",  32'(pe_data_o),   32'(plane_of(vb, 0)));
        check("same_pend_empty", 32'(act_ready_o), 32'd1);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Signed: element 0 = 4'b1000 flags the sign only on the last plane.
        step(1'b0, 1'b1, 32'h0000_0008, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("sign_flag", 32'(pe_sign_o), 32'(k == 3));
            check("sign_data", 32'(pe_data_o), 32'((k == 3) ? 8'h01 : 8'h00));
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end

        // Reset mid-vector with a pending vector queued.
        step(1'b0, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b1);
        check("mid_plane", 32'(pe_plane_o), 32'd1);
        check("mid_busy",  32'(busy_o),     32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("mid_cnt",   32'(vec_cnt_o),  32'd0);
        check("mid_valid", 32'(pe_valid_o), 32'd0);

        // Randomized traffic, long enough for the 4-bit counter to wrap.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                 $urandom, ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_act_serializer.md
Name: pe_act_serializer

Overview:
- Transmit side of the PE activation interface.
- Accepts full multi-bit activation vectors from the activation buffer/loader and streams them into the PE as 1-bit planes, LSB first, one plane per accepted beat.
- Drives the PE's bit-wide input bus plus valid.
- Two-entry buffering (active plus pending) lets the loader run ahead, so back-to-back vectors stream with no bubbles.

Parameters:
- PE_SIZE, 1024, number of PE input lines (4 SA rows x 256 SA rows per row); width of one bit-plane.
- ACT_BITS, 4, activation precision; planes per vector.
- SIGNED_ACTS, 0, 1 = MSB plane carries two's-complement sign weight (flagged on pe_sign_o).
- CNT_W, 16, width of the completed-vector counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- act_valid_i  in  1  upstream vector valid.
- act_ready_o  out  1  upstream ready; equals !rst && !pending_valid (no combinational path from pe_ready_i).
- act_i  in  PE_SIZE*ACT_BITS  packed vector; element i occupies bits [i*ACT_BITS +: ACT_BITS].
- pe_valid_o  out  1  plane valid to PE.
- pe_ready_i  in  1  PE accepts plane.
- pe_data_o  out  PE_SIZE  bit i = bit plane_idx of element i.
- pe_plane_o  out  $clog2(ACT_BITS)  current plane index (0 = LSB).
- pe_last_o  out  1  current plane is ACT_BITS-1.
- pe_sign_o  out  1  pe_last_o && SIGNED_ACTS.
- vec_cnt_o  out  CNT_W  vectors fully sent; wraps modulo 2^CNT_W.
- busy_o  out  1  active or pending holds data.

Behaviour:
- Reset (rst=1 at edge): active_valid=0, pending_valid=0, plane=0, vec_cnt_o=0. Consequently pe_valid_o=0, pe_data_o=0, pe_plane_o=0, pe_last_o=0, pe_sign_o=0, busy_o=0, act_ready_o=0 while rst=1.
  - Reset mid-vector discards active and pending with no partial completion counted.
- State per slot: IDLE (active empty) / SEND (active valid). The pending slot is a flag plus register.
- Accept: act_valid_i && act_ready_o at an edge. Destination:
  - Active, if active is empty, or active is retiring this same edge and pending is empty.
  - Otherwise pending.
- Send: pe_valid_o = active_valid. pe_data_o is derived from the active register and plane; it is 0 when !pe_valid_o.
- Beat = pe_valid_o && pe_ready_i.
  - On a beat with plane<ACT_BITS-1: plane++.
  - On a beat with plane==ACT_BITS-1 (retire): plane→0 and vec_cnt_o++. Active reloads from pending if pending_valid (pending clears), else from a same-edge accept, else active_valid→0.
- Stall: while pe_valid_o && !pe_ready_i, pe_data_o, pe_plane_o, pe_last_o and pe_sign_o hold stable.
- Latency: a vector accepted at edge t into an empty block gives pe_valid_o=1 with plane 0 after edge t.
- Throughput: exactly ACT_BITS beats per vector. No idle cycle between vectors when pending (or a same-edge accept) is available and pe_ready_i=1.
- act_ready_o=0 whenever pending is full, even if active retires that edge. The vacated pending slot reopens the next cycle.
- busy_o = active_valid || pending_valid.
- Counter wrap: 2^CNT_W-1 → 0 on retire.

Test Plan (bench overrides PE_SIZE=8, ACT_BITS=4):
- Reset: hold rst 3 cycles with act_valid_i=1 → act_ready_o=0, pe_valid_o=0, pe_data_o=0, vec_cnt_o=0. After release act_ready_o=1 and nothing is accepted before release.
- Single vector, elements {0..7}={1,2,3,4,5,6,7,15}, pe_ready_i=1 → after accept at edge t, planes at t+1..t+4 are pe_data_o = 8'hD5, 8'hE6, 8'hF8, 8'h80. pe_last_o only on the 4th plane, then vec_cnt_o=1 and pe_valid_o=0.
- Back-to-back: three vectors offered continuously → 12 consecutive beats with no gap. act_ready_o drops once pending fills and reasserts one cycle after each pending→active transfer. vec_cnt_o=3.
- Backpressure: pe_ready_i=0 for 5 cycles at plane 2 → pe_data_o and pe_plane_o=2 hold all 5 cycles. Completion is delayed exactly 5 cycles.
- Same-edge retire and accept with pending empty: offer vector B on the edge of A's last beat → B plane 0 is valid the next cycle with no bubble, and pending stays empty.
- SIGNED_ACTS=1, element value 4'b1000 → pe_sign_o=1 only with pe_last_o. Reset asserted mid-vector (plane 1) discards everything with vec_cnt_o unchanged at 0.
